serial_subtracter: RTL and testbench



---
 rtl/serial_subtracter.sv | 178 +++++++++++++++++
 tb/tb_serial_subtracter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtracter.sv
// serial_subtracter
// Multi-cycle subtracter computing (a - b - bin) mod 2^WIDTH, DIGIT bits per
// clock, least significant digit first, through a registered borrow chain.
//
// Parameters:
//   WIDTH      operand / result width (>= 1)
//   DIGIT      bits processed per clock; WIDTH must be a multiple of DIGIT
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   start      request a new operation; honoured only when not busy
//   a, b, bin  minuend, subtrahend, borrow-in; sampled on an accepted start
//   busy       operation in progress
//   done       one-cycle pulse, new result valid
//   difference (a - b - bin) mod 2^WIDTH, held until the next completion
//   bout       borrow-out (a < b + bin, unsigned)
//   overflow   two's-complement overflow of the subtraction
module serial_subtracter #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             bout,
    output logic             overflow
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_subtracter: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One digit of the borrow chain; the extra top bit is the borrow-out,
    // i.e. the sign of the (DIGIT+1)-bit difference.
    function automatic logic [DIGIT:0] digit_sub(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             br
    );
        digit_sub = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, br};
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [CW-1:0]    count_r;
    logic             borrow_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic [WIDTH-1:0] part_r;

    logic [DIGIT:0]   sub_s;
    logic             borrow_next_s;
    logic [WIDTH-1:0] part_next_s;
    logic             ovf_s;
    logic             last_s;

    // Next-state decode for the IDLE / RUN / DONE controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Digit datapath: operands are shifted right each step so the current
    // digit always sits at bit 0; result digits enter the partial register
    // at the top, so after STEPS shifts the first digit reaches bit 0.
    always_comb begin
        last_s        = (count_r == LAST);
        sub_s         = digit_sub(a_r[DIGIT-1:0], b_r[DIGIT-1:0], borrow_r);
        borrow_next_s = sub_s[DIGIT];
        part_next_s   = (part_r >> DIGIT) | (WIDTH'(sub_s[DIGIT-1:0]) << (WIDTH - DIGIT));
        ovf_s         = (a_msb_r != b_msb_r) && (part_next_s[WIDTH-1] != a_msb_r);
    end

    // State register and handshake outputs, decoded from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s == RUN);
            done    <= (state_next_s == DONE);
        end
    end

    // Operand capture, digit stepping and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r    <= {CW{1'b0}};
            borrow_r   <= 1'b0;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            a_msb_r    <= 1'b0;
            b_msb_r    <= 1'b0;
            part_r     <= {WIDTH{1'b0}};
            difference <= {WIDTH{1'b0}};
            bout       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        a_r      <= a;
                        b_r      <= b;
                        a_msb_r  <= a[WIDTH-1];
                        b_msb_r  <= b[WIDTH-1];
                        borrow_r <= bin;
                        count_r  <= {CW{1'b0}};
                        part_r   <= {WIDTH{1'b0}};
                    end
                end
                RUN: begin
                    a_r      <= a_r >> DIGIT;
                    b_r      <= b_r >> DIGIT;
                    part_r   <= part_next_s;
                    borrow_r <= borrow_next_s;
                    count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        difference <= part_next_s;
                        bout       <= borrow_next_s;
                        overflow   <= ovf_s;
                    end
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtracter.sv
module tb_serial_subtracter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // DUT 1: WIDTH=8, DIGIT=1
    logic       start1, bin1, busy1, done1, bout1, ov1;
    logic [7:0] a1, b1, d1;
    // DUT 2: WIDTH=4, DIGIT=2
    logic       start2, bin2, busy2, done2, bout2, ov2;
    logic [3:0] a2, b2, d2;
    // DUT 3: WIDTH=8, DIGIT=8
    logic       start3, bin3, busy3, done3, bout3, ov3;
    logic [7:0] a3, b3, d3;

    serial_subtracter #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .difference(d1), .bout(bout1), .overflow(ov1)
    );
    serial_subtracter #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .difference(d2), .bout(bout2), .overflow(ov2)
    );
    serial_subtracter #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .difference(d3), .bout(bout3), .overflow(ov3)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Expected held results of DUT 1
    logic [7:0] prev_d1;
    logic       prev_b1, prev_o1;

    // Sweep model variables
    logic [3:0] ea, eb, ed;
    logic       ebi, ebo, eov;
    logic [4:0] full;

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    // One full operation on DUT 1; poke>0 re-pulses start with other operands
    // at that RUN cycle, which must be ignored.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] ed8, input logic eb8, input logic eo8, input int poke);
        @(negedge clk);
        a1 = a; b1 = b; bin1 = bi; start1 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start1 = (c == poke);
            if (c == poke) begin
                a1 = 8'hFF; b1 = 8'h00; bin1 = 1'b1;
            end else begin
                a1 = ~a; b1 = ~b; bin1 = ~bi;
            end
            chk(tag, "busy_run", busy1, 32'd1);
            chk(tag, "done_run", done1, 32'd0);
            chk(tag, "diff_hold", d1, prev_d1);
            chk(tag, "bout_hold", bout1, prev_b1);
            chk(tag, "ovf_hold", ov1, prev_o1);
        end
        @(negedge clk);
        start1 = 1'b0;
        chk(tag, "busy_end", busy1, 32'd0);
        chk(tag, "done_end", done1, 32'd1);
        chk(tag, "diff", d1, ed8);
        chk(tag, "bout", bout1, eb8);
        chk(tag, "ovf", ov1, eo8);
        prev_d1 = ed8; prev_b1 = eb8; prev_o1 = eo8;
        @(negedge clk);
        chk(tag, "done_fall", done1, 32'd0);
        chk(tag, "busy_idle", busy1, 32'd0);
        chk(tag, "diff_after", d1, prev_d1);
    endtask

    initial begin
        rst_n = 1'b0;
        start1 = 1'b0; a1 = 8'h00; b1 = 8'h00; bin1 = 1'b0;
        start2 = 1'b0; a2 = 4'h0;  b2 = 4'h0;  bin2 = 1'b0;
        start3 = 1'b0; a3 = 8'h00; b3 = 8'h00; bin3 = 1'b0;
        prev_d1 = 8'h00; prev_b1 = 1'b0; prev_o1 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset", "busy1", busy1, 32'd0);
        chk("reset", "done1", done1, 32'd0);
        chk("reset", "diff1", d1, 32'd0);
        chk("reset", "bout1", bout1, 32'd0);
        chk("reset", "ovf1", ov1, 32'd0);
        chk("reset", "busy2", busy2, 32'd0);
        chk("reset", "diff2", d2, 32'd0);
        chk("reset", "busy3", busy3, 32'd0);
        chk("reset", "diff3", d3, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle", "busy1", busy1, 32'd0);
        chk("idle", "done1", done1, 32'd0);

        // Directed W8/D1 vectors
        op8("sub35_12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 0);
        op8("sub00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
        op8("sub00_00b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
        op8("sub80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
        op8("sub7F_FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0);

        // start re-pulsed mid-RUN is ignored
        op8("repulse", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 3);

        // Reset mid-RUN discards the operation
        @(negedge clk);
        a1 = 8'h80; b1 = 8'h01; bin1 = 1'b0; start1 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            chk("midrst", "busy_run", busy1, 32'd1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst", "busy", busy1, 32'd0);
        chk("midrst", "done", done1, 32'd0);
        chk("midrst", "diff", d1, 32'd0);
        chk("midrst", "bout", bout1, 32'd0);
        chk("midrst", "ovf", ov1, 32'd0);
        prev_d1 = 8'h00; prev_b1 = 1'b0; prev_o1 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("midrst", "no_done", done1, 32'd0);
            chk("midrst", "no_busy", busy1, 32'd0);
        end
        op8("after_rst", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);

        // W8/D8: single-cycle latency
        @(negedge clk);
        a3 = 8'hA0; b3 = 8'h0B; bin3 = 1'b1; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0; a3 = 8'h00; b3 = 8'hFF; bin3 = 1'b0;
        chk("d8", "busy_run", busy3, 32'd1);
        chk("d8", "done_run", done3, 32'd0);
        chk("d8", "diff_hold", d3, 32'd0);
        @(negedge clk);
        chk("d8", "busy_end", busy3, 32'd0);
        chk("d8", "done_end", done3, 32'd1);
        chk("d8", "diff", d3, 32'h94);
        chk("d8", "bout", bout3, 32'd0);
        chk("d8", "ovf", ov3, 32'd0);
        @(negedge clk);
        chk("d8", "done_fall", done3, 32'd0);

        // W4/D2 exhaustive back-to-back sweep
        @(negedge clk);
        for (int i = 0; i < 512; i++) begin
            ea  = i[8:5];
            eb  = i[4:1];
            ebi = i[0];
            full = {1'b0, ea} - {1'b0, eb} - {4'b0000, ebi};
            ed  = full[3:0];
            ebo = ({1'b0, ea} < ({1'b0, eb} + {4'b0000, ebi}));
            eov = (ea[3] != eb[3]) && (ed[3] != ea[3]);
            a2 = ea; b2 = eb; bin2 = ebi; start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0; a2 = ~ea; b2 = ~eb; bin2 = ~ebi;
            chk("sweep", "busy1", busy2, 32'd1);
            chk("sweep", "done1", done2, 32'd0);
            @(negedge clk);
            chk("sweep", "busy2", busy2, 32'd1);
            chk("sweep", "done2", done2, 32'd0);
            @(negedge clk);
            chk("sweep", "busy_end", busy2, 32'd0);
            chk("sweep", "done_end", done2, 32'd1);
            chk("sweep", "diff", d2, {28'd0, ed});
            chk("sweep", "bout", bout2, {31'd0, ebo});
            chk("sweep", "ovf", ov2, {31'd0, eov});
        end
        @(negedge clk);
        chk("sweep", "done_fall", done2, 32'd0);
        chk("sweep", "busy_idle", busy2, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
